mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: LATENCY, 2, memory cycles from address issue to valid mem_rdata; legal 1..7.
REQ-002 Parameter: XLEN, 32, data/address width.
REQ-003 Ports: clock  in  1  clock; all sequential logic on rising edge.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 req_read  in  1  load request from multicycle control unit.
REQ-006 req_write  in  1  store request from multicycle control unit.
REQ-007 addr  in  32  byte address (PC or ALU result, already muxed by IorD).
REQ-008 wdata  in  32  store data (rs2, right-aligned).
REQ-009 funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 rdata  out  32  extended load data, right-aligned.
REQ-011 ready  out  1  one-cycle completion pulse.
REQ-012 busy  out  1  access in progress; new requests ignored.
REQ-013 misaligned  out  1  completion flag: access suppressed for misalignment.
REQ-014 mem_addr  out  32  word-aligned address {addr[31:2],2'b00}; mem_re  out  1; mem_we  out  1; mem_be  out  4  byte enables; mem_wdata  out  32  lane-shifted data; mem_rdata  in  32.

Function
REQ-015 FSM states IDLE, WAIT, DONE; typedef in shared package.
REQ-016 IDLE: req_read or req_write high -> latch addr, funct3, wdata; go WAIT; counter loaded with LATENCY-1.
REQ-017 req_read and req_write both high: treated as read; write ignored.
REQ-018 WAIT: busy=1; mem_addr driven from latched address every WAIT cycle; mem_re=1 every cycle for reads.
REQ-019 Store: mem_we=1 only in first WAIT cycle, mem_be per size and addr[1:0] (SB 0001<<a, SH 0011<<a, SW 1111), mem_wdata = replicated byte/half/word lanes.
REQ-020 WAIT decrements counter; at counter 0 captures mem_rdata into internal register and goes DONE.
REQ-021 Latency: request sampled at edge N -> ready high in cycle N+LATENCY+1; LATENCY=2 gives ready 3 cycles after accept.
REQ-022 DONE: ready=1 and busy=0 for exactly one cycle; return to IDLE; requests in DONE ignored.
REQ-023 rdata: selected byte/half shifted by addr[1:0], sign-extended (B,H) or zero-extended (BU,HU); holds until next completion.
REQ-024 Stores leave rdata unchanged.
REQ-025 funct3 values 011, 110, 111 treated as W.
REQ-026 Requests mid-access (busy=1) have no effect, not queued.

Reset
REQ-027 Reset (any time, incl. mid-WAIT) -> IDLE, counter 0, rdata 0, ready 0, busy 0, misaligned 0, mem_re 0, mem_we 0, mem_be 0; aborted access produces no ready.

Configuration
REQ-028 MEM_MISALIGN_CHECK_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 -> IDLE to DONE directly (ready next cycle), no mem_re/mem_we, misaligned=1 with ready, rdata unchanged.
REQ-029 Undefined: misaligned tied 0; H uses addr[1] only, W ignores addr[1:0]; normal latency.

Structure
REQ-030 Shared package: FSM state typedef, funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), alongside existing opcode constants.
REQ-031 One combinational sub-module load_extend (size, addr[1:0], word -> extended data); store lane logic inline.

Verification
REQ-032 LATENCY=2, mem word 0x8081_7F02 @0x100, LB addr 0x100 -> mem_re 2 cycles, ready 3 cycles after accept, rdata 0x0000_0002.
REQ-033 Same word, LB addr 0x103 -> 0xFFFF_FF80; LBU 0x103 -> 0x0000_0080; LH 0x102 -> 0xFFFF_8081.
REQ-034 SB addr 0x101 wdata 0x0000_00AB -> single-cycle mem_we, mem_be 0010, mem_wdata[15:8]=0xAB, ready 3 cycles later.
REQ-035 With MEM_MISALIGN_CHECK_EN, LW addr 0x102 -> ready+misaligned next cycle, mem_re never asserted; without macro -> normal word read of 0x100.
REQ-036 Reset asserted in WAIT cycle 1 -> all outputs 0 immediately, no ready; next LW completes normally.
REQ-037 req_read and req_write both high, then req_read held during busy -> one read only, one ready pulse, mem_we never asserted.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the multicycle core: opcodes, load/store size codes, memory FSM state.
package mem_access_unit_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mau_state_e;

  // Unlisted funct3 encodings collapse to word accesses.
  function automatic logic [1:0] size_of(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: size_of = SZ_B;
      F3_H, F3_HU: size_of = SZ_H;
      default:     size_of = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Selects the addressed byte/half of a memory word and sign- or zero-extends it.
module load_extend
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      size,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{offset, 3'b000} +: 8];
    half_v = word[{offset[1], 4'b0000} +: 16];
    data   = word;
    case (size)
      F3_B:    data = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_BU:   data = {{(XLEN-8){1'b0}}, byte_v};
      F3_H:    data = {{(XLEN-16){half_v[15]}}, half_v};
      F3_HU:   data = {{(XLEN-16){1'b0}}, half_v};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the multicycle control unit and a fixed-latency memory.
// Optional MEM_MISALIGN_CHECK_EN: misaligned H/W accesses complete at once with a flag instead of touching memory.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int XLEN    = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_read,
  input  logic            req_write,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] rdata,
  output logic            ready,
  output logic            busy,
  output logic            misaligned,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_re,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  mau_state_e      state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      f3_q, f3_d;
  logic            is_read_q, is_read_d;
  logic            first_q, first_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [XLEN-1:0] load_data;

`ifdef MEM_MISALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;
  logic req_misaligned;

  assign req_misaligned = ((size_of(funct3) == SZ_H) && addr[0]) ||
                          ((size_of(funct3) == SZ_W) && (addr[1:0] != 2'b00));
  assign misaligned     = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .size   (f3_q),
    .offset (addr_q[1:0]),
    .word   (mem_rdata),
    .data   (load_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    is_read_d = is_read_q;
    first_d   = first_q;
    rdata_d   = rdata_q;
`ifdef MEM_MISALIGN_CHECK_EN
    misaligned_d = misaligned_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_read || req_write) begin
          addr_d    = addr;
          wdata_d   = wdata;
          f3_d      = funct3;
          is_read_d = req_read;  // read wins when both are raised
          first_d   = 1'b1;
          cnt_d     = CNT_INIT;
`ifdef MEM_MISALIGN_CHECK_EN
          if (req_misaligned) begin
            state_d      = DONE;
            misaligned_d = 1'b1;
          end else begin
            state_d = WAIT;
          end
`else
          state_d = WAIT;
`endif
        end
      end
      WAIT: begin
        first_d = 1'b0;
        if (cnt_q == 3'd0) begin
          if (is_read_q) rdata_d = load_data;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef MEM_MISALIGN_CHECK_EN
        misaligned_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      is_read_q <= 1'b0;
      first_q   <= 1'b0;
      rdata_q   <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      f3_q      <= f3_d;
      is_read_q <= is_read_d;
      first_q   <= first_d;
      rdata_q   <= rdata_d;
`ifdef MEM_MISALIGN_CHECK_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  assign busy     = (state_q == WAIT);
  assign ready    = (state_q == DONE);
  assign rdata    = rdata_q;
  assign mem_addr = busy ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign mem_re   = busy && is_read_q;
  assign mem_we   = busy && !is_read_q && first_q;

  // Store lanes: data replicated across the word, enables pick the addressed lanes.
  always_comb begin
    mem_be    = 4'b0000;
    mem_wdata = '0;
    if (mem_we) begin
      case (size_of(f3_q))
        SZ_B: begin
          mem_be    = 4'b0001 << addr_q[1:0];
          mem_wdata = {(XLEN/8){wdata_q[7:0]}};
        end
        SZ_H: begin
          mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {(XLEN/16){wdata_q[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = wdata_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (LATENCY=2); expectations adapt to MEM_MISALIGN_CHECK_EN.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rdata;
  logic        ready, busy, misaligned;
  logic [31:0] mem_addr;
  logic        mem_re, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign mem_rdata = mem_re ? mem[mem_addr[9:2]] : 32'hDEAD_BEEF;

  mem_access_unit #(.LATENCY(2), .XLEN(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_read   (req_read),
    .req_write  (req_write),
    .addr       (addr),
    .wdata      (wdata),
    .funct3     (funct3),
    .rdata      (rdata),
    .ready      (ready),
    .busy       (busy),
    .misaligned (misaligned),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Issues one request and watches it (bounded) until ready; stores are applied to the memory model.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic hold_rd,
                            output int ready_at, output int re_cycles, output int we_cycles,
                            output logic [3:0] be_seen, output logic [31:0] wd_seen,
                            output logic [31:0] addr_seen, output logic mis_seen);
    @(negedge clock);
    req_read = rd; req_write = wr; funct3 = f3; addr = a; wdata = wd;
    @(posedge clock); #1;
    if (!hold_rd) req_read = 1'b0;
    req_write = 1'b0;
    ready_at = -1; re_cycles = 0; we_cycles = 0;
    be_seen = '0; wd_seen = '0; addr_seen = '0; mis_seen = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (mem_re || mem_we) addr_seen = mem_addr;
      if (mem_re) re_cycles++;
      if (mem_we) begin
        we_cycles++;
        be_seen = mem_be;
        wd_seen = mem_wdata;
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
      end
      if (ready) begin
        ready_at = c;
        mis_seen = misaligned;
        break;
      end
    end
    req_read = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ready, busy, misaligned, mem_re, mem_we, mem_be} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000000", {ready, busy, misaligned, mem_re, mem_we, mem_be});
    end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
    checks++;
    if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 00000000", mem_addr); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_loads();
    logic [2:0]  tf3 [0:7];
    logic [31:0] ta  [0:7];
    logic [31:0] te  [0:7];
    int rdy, re, we; logic [3:0] be; logic [31:0] wds, as; logic ms;
    tf3[0] = 3'b000; ta[0] = 32'h100; te[0] = 32'h0000_0002;
    tf3[1] = 3'b000; ta[1] = 32'h103; te[1] = 32'hFFFF_FF80;
    tf3[2] = 3'b100; ta[2] = 32'h103; te[2] = 32'h0000_0080;
    tf3[3] = 3'b001; ta[3] = 32'h102; te[3] = 32'hFFFF_8081;
    tf3[4] = 3'b101; ta[4] = 32'h102; te[4] = 32'h0000_8081;
    tf3[5] = 3'b000; ta[5] = 32'h101; te[5] = 32'h0000_007F;
    tf3[6] = 3'b010; ta[6] = 32'h100; te[6] = 32'h8081_7F02;
    tf3[7] = 3'b111; ta[7] = 32'h100; te[7] = 32'h8081_7F02;
    for (int i = 0; i < 8; i++) begin
      run_access(1'b1, 1'b0, tf3[i], ta[i], 32'h0, 1'b0, rdy, re, we, be, wds, as, ms);
      checks++;
      if (rdata !== te[i]) begin errors++; $display("FAIL load%0d_rdata: got %h expected %h", i, rdata, te[i]); end
      checks++;
      if (rdy !== 3) begin errors++; $display("FAIL load%0d_latency: got %0d expected 3", i, rdy); end
      checks++;
      if (re !== 2 || we !== 0) begin errors++; $display("FAIL load%0d_strobes: got re=%0d we=%0d expected re=2 we=0", i, re, we); end
      checks++;
      if (as !== 32'h100) begin errors++; $display("FAIL load%0d_mem_addr: got %h expected 00000100", i, as); end
    end
  endtask

  task automatic test_misaligned();
    int rdy, re, we; logic [3:0] be; logic [31:0] wds, as; logic ms;
    run_access(1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 1'b0, rdy, re, we, be, wds, as, ms);
    run_access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 1'b0, rdy, re, we, be, wds, as, ms);
`ifdef MEM_MISALIGN_CHECK_EN
    checks++;
    if (rdy !== 1 || ms !== 1'b1) begin errors++; $display("FAIL misalign_flag: got ready_at=%0d mis=%b expected 1 1", rdy, ms); end
    checks++;
    if (re !== 0) begin errors++; $display("FAIL misalign_no_re: got %0d expected 0", re); end
    checks++;
    if (rdata !== 32'h0000_0002) begin errors++; $display("FAIL misalign_rdata: got %h expected 00000002", rdata); end
`else
    checks++;
    if (rdy !== 3 || ms !== 1'b0) begin errors++; $display("FAIL misalign_flag: got ready_at=%0d mis=%b expected 3 0", rdy, ms); end
    checks++;
    if (re !== 2 || as !== 32'h100) begin errors++; $display("FAIL misalign_read: got re=%0d addr=%h expected 2 00000100", re, as); end
    checks++;
    if (rdata !== 32'h8081_7F02) begin errors++; $display("FAIL misalign_rdata: got %h expected 80817f02", rdata); end
`endif
  endtask

  task automatic test_stores();
    int rdy, re, we; logic [3:0] be; logic [31:0] wds, as; logic ms;
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, rdy, re, we, be, wds, as, ms);
    run_access(1'b0, 1'b1, 3'b000, 32'h101, 32'h0000_00AB, 1'b0, rdy, re, we, be, wds, as, ms);
    checks++;
    if (we !== 1 || re !== 0) begin errors++; $display("FAIL sb_strobes: got we=%0d re=%0d expected 1 0", we, re); end
    checks++;
    if (be !== 4'b0010) begin errors++; $display("FAIL sb_be: got %b expected 0010", be); end
    checks++;
    if (wds !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata: got %h expected abababab", wds); end
    checks++;
    if (rdy !== 3 || as !== 32'h100) begin errors++; $display("FAIL sb_timing: got ready_at=%0d addr=%h expected 3 00000100", rdy, as); end
    checks++;
    if (rdata !== 32'h8081_7F02) begin errors++; $display("FAIL sb_rdata_kept: got %h expected 80817f02", rdata); end
    run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'hFFFF_1234, 1'b0, rdy, re, we, be, wds, as, ms);
    checks++;
    if (be !== 4'b1100 || wds !== 32'h1234_1234) begin errors++; $display("FAIL sh_lanes: got be=%b wd=%h expected 1100 12341234", be, wds); end
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, rdy, re, we, be, wds, as, ms);
    checks++;
    if (rdata !== 32'h1234_AB02) begin errors++; $display("FAIL store_readback: got %h expected 1234ab02", rdata); end
  endtask

  task automatic test_reset_mid_wait();
    int rdy, re, we, extra; logic [3:0] be; logic [31:0] wds, as; logic ms;
    @(negedge clock);
    req_read = 1'b1; funct3 = 3'b010; addr = 32'h100;
    @(posedge clock); #1;
    req_read = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b1 || mem_re !== 1'b1) begin errors++; $display("FAIL abort_in_wait: got busy=%b re=%b expected 1 1", busy, mem_re); end
    reset = 1'b1;
    #1;
    checks++;
    if ({ready, busy, misaligned, mem_re, mem_we, mem_be} !== 9'b0 || rdata !== 32'h0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL abort_outputs: got ctrl=%b rdata=%h addr=%h expected all zero",
               {ready, busy, misaligned, mem_re, mem_we, mem_be}, rdata, mem_addr);
    end
    @(negedge clock);
    reset = 1'b0;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (ready) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL abort_no_ready: got %0d pulses expected 0", extra); end
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, rdy, re, we, be, wds, as, ms);
    checks++;
    if (rdy !== 3 || rdata !== 32'h1234_AB02) begin errors++; $display("FAIL after_abort_lw: got ready_at=%0d rdata=%h expected 3 1234ab02", rdy, rdata); end
  endtask

  task automatic test_read_write_collision();
    int rdy, re, we, extra; logic [3:0] be; logic [31:0] wds, as; logic ms;
    run_access(1'b1, 1'b1, 3'b000, 32'h100, 32'hFFFF_FFFF, 1'b1, rdy, re, we, be, wds, as, ms);
    checks++;
    if (we !== 0 || re !== 2) begin errors++; $display("FAIL collide_strobes: got we=%0d re=%0d expected 0 2", we, re); end
    checks++;
    if (rdy !== 3 || rdata !== 32'h0000_0002) begin errors++; $display("FAIL collide_read: got ready_at=%0d rdata=%h expected 3 00000002", rdy, rdata); end
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (ready || busy) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL collide_single: got %0d extra active cycles expected 0", extra); end
    checks++;
    if (mem[64] !== 32'h1234_AB02) begin errors++; $display("FAIL collide_mem: got %h expected 1234ab02", mem[64]); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[64] = 32'h8081_7F02;
    test_reset();
    test_loads();
    test_misaligned();
    test_stores();
    test_reset_mid_wait();
    test_read_write_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
